fa: RTL and testbench
=====================

FA -- requirements
Module: fa

Interface
REQ-001 Parameter: CNT_W, 16, width of the output-activity counter (range 4..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: a  input  1  addend bit.
REQ-005 Port: b  input  1  addend bit.
REQ-006 Port: cin  input  1  carry-in bit.
REQ-007 Port: sum  output  1  combinational sum, a XOR b XOR cin.
REQ-008 Port: carry  output  1  combinational carry-out, majority(a, b, cin).
REQ-009 Port: cnt_clr  input  1  synchronous clear of the activity counter.
REQ-010 Port: sum_q  output  1  registered sum.
REQ-011 Port: carry_q  output  1  registered carry.
REQ-012 Port: act_cnt  output  CNT_W  count of clock edges on which {sum,carry} differed from {sum_q,carry_q}.

Function
REQ-013 sum and carry SHALL be purely combinational with zero latency, independent of clk, rst and all state.
REQ-014 sum and carry SHALL settle to the truth table for all 8 input combinations, with no clock applied.
REQ-015 Truth table for {a,b,cin} -> {carry,sum}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
REQ-016 sum_q and carry_q SHALL capture sum and carry on each rising clk edge, for one cycle of latency.
REQ-017 On a rising edge where {sum,carry} != {sum_q,carry_q}, act_cnt SHALL increment by 1.
REQ-018 act_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 cnt_clr SHALL set act_cnt to 0 on the next edge, with priority over increment; sum_q and carry_q are unaffected.
REQ-020 X/Z on a, b or cin SHALL NOT be masked: the outputs propagate X under simulation.

Reset
REQ-021 While rst=1, sum_q=0, carry_q=0 and act_cnt=0, applied immediately without waiting for a clk edge.
REQ-022 A transition detected on the first edge after rst deasserts SHALL be counted against the reset value {0,0}.
REQ-023 rst SHALL NOT affect the combinational sum and carry.
REQ-024 Reset asserted mid-operation SHALL clear all state within the same delta; counting resumes from 0 after release.

Structure
REQ-025 The default for CNT_W and the 3-bit truth-table constant used by the bench SHALL reside in shared package fa_pkg.
REQ-026 The combinational path SHALL be built from two instances of sub-module half_adder (ports a, b, s, c) plus an OR for carry.
REQ-027 The registered and counter logic SHALL reside in fa itself; no further sub-modules.

Verification
REQ-028 Exhaustive combinational test: hold clk=0, rst=0; sweep {a,b,cin} 000..111 at 100 ns steps -> sum/carry match REQ-015 at each step.
REQ-029 Register latency: apply rst pulse, set a=1,b=1,cin=1, one clk edge -> sum_q=1, carry_q=1, act_cnt=1.
REQ-030 Async reset: with act_cnt=5, assert rst between edges -> sum_q=0, carry_q=0, act_cnt=0 immediately; sum/carry unchanged.
REQ-031 Saturation: CNT_W=4, alternate inputs 000/111 each cycle for 20 cycles -> act_cnt stops at 15.
REQ-032 Clear priority: act_cnt=3, cnt_clr=1 coincident with an output change -> act_cnt=0 after the edge.
REQ-033 No-change inputs: hold 011 for 10 cycles after the first capture -> act_cnt does not increase.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared constants for the full adder slice: counter width default and the
// reference {carry,sum} truth table indexed by {a,b,cin}.
package fa_pkg;

    // Default width of the output-activity counter.
    localparam int CNT_W_DEFAULT = 16;

    // Two bits per input combination, {carry,sum}, entry n at bits [2n+1:2n].
    // 111->11 110->10 101->10 100->01 011->10 010->01 001->01 000->00
    localparam logic [15:0] FA_TRUTH = 16'hE994;

    // Look up the expected {carry,sum} for one {a,b,cin} combination.
    function automatic logic [1:0] fa_truth(input logic [2:0] abc);
        return FA_TRUTH[int'(abc)*2 +: 2];
    endfunction

endpackage

// File: rtl/fa_half_adder.sv
// Half adder: the building block of the full adder's combinational path.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Plain gates so X on any input propagates to the outputs.
    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/fa.sv
// Full adder with a registered copy of its outputs and a saturating counter
// of clock edges on which the combinational outputs differ from the registered ones.
module fa
    import fa_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             carry,
    input  logic             cnt_clr,
    output logic             sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] act_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s0, c0, s1, c1;
    logic sum_d, carry_d;
    logic changed;
    logic [CNT_W-1:0] act_cnt_d, act_cnt_q;

    // First stage adds a and b, second stage folds in the carry-in.
    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s1), .c(c1));

    // Combinational outputs; no clock, reset or state in this path.
    assign sum   = s1;
    assign carry = c0 | c1;

    // Next-state: capture outputs, count edges where they differ from the
    // registered copy; clear wins over increment, counter saturates.
    always_comb begin
        sum_d     = sum;
        carry_d   = carry;
        changed   = ({sum, carry} != {sum_q, carry_q});
        act_cnt_d = act_cnt_q;
        if (cnt_clr) begin
            act_cnt_d = '0;
        end else if (changed && (act_cnt_q != CNT_MAX)) begin
            act_cnt_d = act_cnt_q + CNT_ONE;
        end
    end

    // State register; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            act_cnt_q <= '0;
        end else begin
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            act_cnt_q <= act_cnt_d;
        end
    end

    assign act_cnt = act_cnt_q;

endmodule

// File: tb/tb_fa.sv
// Scoreboard bench for fa: directed vectors push expected responses into a
// queue; a monitor pops and compares each time a sample is announced.
module tb_fa;
    import fa_pkg::*;

    // Each expectation: mask selects which fields are compared.
    // mask[3]=comb {carry,sum}, [2]=registered {carry_q,sum_q},
    // [1]=16-bit counter, [0]=4-bit counter.
    typedef struct packed {
        logic [3:0]  mask;
        logic [1:0]  comb;
        logic [1:0]  regd;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  check_ev;

    int checks_total  = 0;
    int checks_passed = 0;

    // ---------------- clock / reset / inputs ----------------
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0, b = 1'b0, cin = 1'b0;
    logic cnt_clr = 1'b0;

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // ---------------- DUTs ----------------
    logic        sum, carry, sum_q, carry_q;
    logic [15:0] act_cnt;
    logic        sum4, carry4, sum_q4, carry_q4;
    logic [3:0]  act_cnt4;

    fa u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .sum(sum), .carry(carry), .cnt_clr(cnt_clr),
        .sum_q(sum_q), .carry_q(carry_q), .act_cnt(act_cnt)
    );

    fa #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .sum(sum4), .carry(carry4), .cnt_clr(cnt_clr),
        .sum_q(sum_q4), .carry_q(carry_q4), .act_cnt(act_cnt4)
    );

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [2:0] v);
        {a, b, cin} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [3:0] mask,
                              input logic [1:0] comb, input logic [1:0] regd,
                              input logic [15:0] cnt, input logic [3:0] cnt4);
        exp_t e;
        e.mask = mask;
        e.comb = comb;
        e.regd = regd;
        e.cnt  = cnt;
        e.cnt4 = cnt4;
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> check_ev;
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic cmp(input string nm, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, field, act, exp, $time);
        end
    endtask

    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(check_ev);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.mask[3]) cmp(nm, "comb", {14'd0, carry, sum}, {14'd0, e.comb});
                if (e.mask[2]) cmp(nm, "regd", {14'd0, carry_q, sum_q}, {14'd0, e.regd});
                if (e.mask[1]) cmp(nm, "cnt16", act_cnt, e.cnt);
                if (e.mask[0]) cmp(nm, "cnt4", {12'd0, act_cnt4}, {12'd0, e.cnt4});
            end
        end
    end

    // Watchdog: the sequence is short, so anything this long is a hang.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Exhaustive combinational sweep with the clock stopped.
        for (int i = 0; i < 8; i++) begin
            set_in(i[2:0]);
            #100;
            expect_now("comb_sweep", 4'b1000, fa_truth(i[2:0]), 2'b00, 16'd0, 4'd0);
        end

        // Reset applied with no clock: state clears, comb path unaffected.
        set_in(3'b111);
        rst = 1'b1;
        #10;
        expect_now("reset_hold", 4'b1111, 2'b11, 2'b00, 16'd0, 4'd0);
        #10;
        rst = 1'b0;
        #2;
        clk_en = 1'b1;

        // One edge of latency; transition counted against reset value.
        tick();
        expect_now("latency_111", 4'b0111, 2'b00, 2'b11, 16'd1, 4'd1);

        // Move to 011, then hold it: no further counting.
        set_in(3'b011);
        tick();
        expect_now("capture_011", 4'b0111, 2'b00, 2'b10, 16'd2, 4'd2);
        repeat (10) tick();
        expect_now("hold_011", 4'b0111, 2'b00, 2'b10, 16'd2, 4'd2);

        // Three more changes bring the count to 5.
        set_in(3'b000); tick();
        set_in(3'b001); tick();
        set_in(3'b111); tick();
        expect_now("cnt_five", 4'b0111, 2'b00, 2'b11, 16'd5, 4'd5);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        expect_now("async_rst", 4'b1111, 2'b11, 2'b00, 16'd0, 4'd0);
        rst = 1'b0;

        // First edge after release counts against {0,0}.
        tick();
        expect_now("first_after_rst", 4'b0111, 2'b00, 2'b11, 16'd1, 4'd1);

        // Reach 3, then clear coincident with an output change.
        set_in(3'b000); tick();
        set_in(3'b111); tick();
        expect_now("cnt_three", 4'b0111, 2'b00, 2'b11, 16'd3, 4'd3);
        set_in(3'b000);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        expect_now("clr_priority", 4'b0111, 2'b00, 2'b00, 16'd0, 4'd0);

        // Saturation: 20 alternating cycles; 4-bit counter stops at 15.
        for (int k = 0; k < 20; k++) begin
            set_in((k % 2 == 0) ? 3'b111 : 3'b000);
            tick();
            if (k == 14)
                expect_now("sat_reach", 4'b0111, 2'b00, 2'b11, 16'd15, 4'd15);
        end
        expect_now("sat_hold", 4'b0111, 2'b00, 2'b00, 16'd20, 4'd15);

        // Every expectation must have been consumed by the monitor.
        #2;
        checks_total++;
        if (exp_q.size() == 0) begin
            checks_passed++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
